risc_toy_fetch_queue: RTL and testbench

RISC_TOY_FETCH_QUEUE -- requirements
Module: risc_toy_fetch_queue

---
 rtl/risc_toy_fetch_queue.sv | 96 +++++++++
 tb/tb_risc_toy_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_toy_fetch_queue.sv
// Instruction fetch front end: a sequential PC, a one-cycle-latency memory
// handshake, and a small in-order queue feeding decode, flushed on redirect.
module risc_toy_fetch_queue #(
  parameter int            AW         = 30,
  parameter int            IW         = 32,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   IREQ,
  output logic [AW-1:0]          IADDR,
  input  logic [IW-1:0]          INSTR,
  input  logic                   REDIR,
  input  logic [AW-1:0]          REDIR_ADDR,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [IW-1:0]          OUT_INSTR,
  output logic [AW-1:0]          OUT_ADDR,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW:0]   FULL_OCC = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] addr;
  } entry_t;

  logic [AW-1:0] pc;
  logic          inflight;
  logic [AW-1:0] req_addr;
  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;
  logic [CW:0]   occupancy;

  assign IADDR     = pc;
  assign COUNT     = count;
  assign OUT_VALID = (count != '0);
  assign OUT_INSTR = mem[rd_ptr].instr;
  assign OUT_ADDR  = mem[rd_ptr].addr;

  // NOTE: every signal of this block is assigned on every pass, so no latch can form.
  always_comb begin
    pop       = OUT_VALID & OUT_READY & ~REDIR;
    push      = inflight & ~REDIR & ~RST;
    // Entries held plus the one landing next cycle, less the one leaving now.
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    IREQ      = ~RST & ~REDIR & (occupancy < FULL_OCC);
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc       <= RESET_ADDR;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (REDIR) begin
      pc       <= REDIR_ADDR;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (IREQ) pc <= pc + AW'(1);
      inflight <= IREQ;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array and request-address latch are not reset; COUNT gates every read.
  always_ff @(posedge CLK) begin
    if (IREQ) req_addr <= pc;
    if (push) mem[wr_ptr] <= '{instr: INSTR, addr: req_addr};
  end

  // A push into a full queue is only legal when the head leaves in the same cycle.
  no_overflow: assert property (@(posedge CLK) disable iff (RST)
    push |-> ((count != FULL_CNT) || pop));

endmodule

// File: tb/tb_risc_toy_fetch_queue.sv
// Bench for risc_toy_fetch_queue: memory model, scoreboard of requested words,
// a hand-derived cycle table, and directed redirect/reset/wrap sequences.
module tb_risc_toy_fetch_queue;

  localparam int AW    = 30;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam logic [AW-1:0] RST_A = '0;

  logic          CLK = 1'b0;
  logic          RST, REDIR, OUT_READY;
  logic [AW-1:0] REDIR_ADDR;
  logic [IW-1:0] INSTR;
  logic          IREQ, OUT_VALID;
  logic [AW-1:0] IADDR, OUT_ADDR;
  logic [IW-1:0] OUT_INSTR;
  logic [CW-1:0] COUNT;

  logic          s_redir, s_ready, s_ireq, s_valid;
  logic [3:0]    s_redir_addr, s_iaddr, s_out_addr;
  logic [IW-1:0] s_instr, s_out_instr;
  logic [CW-1:0] s_count;

  always #5 CLK = ~CLK;

  risc_toy_fetch_queue dut (
    .CLK(CLK), .RST(RST), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .REDIR(REDIR), .REDIR_ADDR(REDIR_ADDR), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR), .OUT_ADDR(OUT_ADDR),
    .COUNT(COUNT)
  );

  risc_toy_fetch_queue #(.AW(4), .RESET_ADDR(4'hE)) dut_small (
    .CLK(CLK), .RST(RST), .IREQ(s_ireq), .IADDR(s_iaddr), .INSTR(s_instr),
    .REDIR(s_redir), .REDIR_ADDR(s_redir_addr), .OUT_VALID(s_valid),
    .OUT_READY(s_ready), .OUT_INSTR(s_out_instr), .OUT_ADDR(s_out_addr),
    .COUNT(s_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] instr;
  } exp_t;

  typedef struct {
    logic          rst;
    logic          rdy;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          ov;
    logic [AW-1:0] oaddr;
    int            cnt;
  } vec_t;

  int            n_vec = 0;
  int            n_bad = 0;
  exp_t          sb[$];
  vec_t          tbl[$];
  logic [3:0]    s_log[$];
  bit            m_known = 0;
  logic [AW-1:0] m_pc = '0;
  int            m_count = 0;
  bit            m_inflight = 0;
  bit            next_valid = 0;
  logic [IW-1:0] next_instr = '0;
  bit            s_next_valid = 0;
  logic [IW-1:0] s_next = '0;

  function automatic logic [IW-1:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hA5A5_0000;
  endfunction

  function automatic vec_t mk(input logic rst, input logic rdy, input logic ireq,
                              input int iaddr, input logic ov, input int oaddr,
                              input int cnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.ireq = ireq; v.iaddr = AW'(iaddr);
    v.ov = ov; v.oaddr = AW'(oaddr); v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, check against the model, advance the model.
  task automatic step(input logic rst, input logic redir, input logic [AW-1:0] raddr,
                      input logic rdy);
    bit   exp_pop, exp_ireq;
    exp_t e;
    @(negedge CLK);
    RST        = rst;
    REDIR      = redir;
    REDIR_ADDR = raddr;
    OUT_READY  = rdy;
    INSTR      = next_valid ? next_instr : 32'hDEAD_BEEF;
    s_instr    = s_next_valid ? s_next : 32'hDEAD_BEEF;
    #1;
    exp_pop  = (m_count != 0) && rdy && !redir;
    exp_ireq = !rst && !redir &&
               (m_count + int'(m_inflight) - int'(exp_pop) < DEPTH);
    if (m_known) begin
      check("ireq", 64'(IREQ), 64'(exp_ireq));
      check("iaddr", 64'(IADDR), 64'(m_pc));
      check("count", 64'(COUNT), 64'(m_count));
      check("out_valid", 64'(OUT_VALID), 64'(m_count != 0));
    end
    if (exp_pop) begin
      e = sb.pop_front();
      check("out_addr", 64'(OUT_ADDR), 64'(e.addr));
      check("out_instr", 64'(OUT_INSTR), 64'(e.instr));
    end
    if (rst) begin
      m_pc = RST_A; m_count = 0; m_inflight = 0; sb.delete(); m_known = 1;
    end else if (redir) begin
      m_pc = raddr; m_count = 0; m_inflight = 0; sb.delete();
    end else begin
      m_count = m_count + int'(m_inflight) - int'(exp_pop);
      if (exp_ireq) begin
        sb.push_back('{addr: m_pc, instr: mem_word(32'(m_pc))});
        m_pc = m_pc + AW'(1);
      end
      m_inflight = exp_ireq;
    end
    next_valid   = (IREQ === 1'b1);
    next_instr   = mem_word(32'(IADDR));
    s_next_valid = (s_ireq === 1'b1);
    s_next       = mem_word(32'(s_iaddr));
    if (rst) s_log.delete();
    else if (s_valid === 1'b1) begin
      s_log.push_back(s_out_addr);
      check("s_out_instr", 64'(s_out_instr), 64'(mem_word(32'(s_out_addr))));
    end
  endtask

  task automatic wait_valid(input string name, input logic [AW-1:0] want);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (OUT_VALID === 1'b1) seen = 1;
    end
    check({name, " valid"}, 64'(OUT_VALID), 64'(1));
    if (seen) check({name, " addr"}, 64'(OUT_ADDR), 64'(want));
  endtask

  initial begin
    vec_t       v;
    int         nreq;
    logic [3:0] exp42 [4];
    s_redir = 1'b0; s_ready = 1'b1; s_redir_addr = 4'h0;
    exp42 = '{4'hE, 4'hF, 4'h0, 4'h1};

    // Reset, free run, then a 5-cycle stall and recovery; all values hand-derived.
    tbl.push_back(mk(1, 1, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1,  1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1,  2, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1,  3, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1,  4, 1, 2, 1));
    tbl.push_back(mk(0, 0, 1,  5, 1, 3, 1));
    tbl.push_back(mk(0, 0, 1,  6, 1, 3, 2));
    tbl.push_back(mk(0, 0, 0,  7, 1, 3, 3));
    tbl.push_back(mk(0, 0, 0,  7, 1, 3, 4));
    tbl.push_back(mk(0, 0, 0,  7, 1, 3, 4));
    tbl.push_back(mk(0, 1, 1,  7, 1, 3, 4));
    tbl.push_back(mk(0, 1, 1,  8, 1, 4, 3));
    tbl.push_back(mk(0, 1, 1,  9, 1, 5, 3));
    tbl.push_back(mk(0, 1, 1, 10, 1, 6, 3));

    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      step(v.rst, 1'b0, '0, v.rdy);
      check($sformatf("v%0d ireq", i), 64'(IREQ), 64'(v.ireq));
      check($sformatf("v%0d iaddr", i), 64'(IADDR), 64'(v.iaddr));
      check($sformatf("v%0d out_valid", i), 64'(OUT_VALID), 64'(v.ov));
      check($sformatf("v%0d count", i), 64'(COUNT), 64'(v.cnt));
      if (v.ov) check($sformatf("v%0d out_addr", i), 64'(OUT_ADDR), 64'(v.oaddr));
    end

    // Stalled consumer from reset: exactly DEPTH requests, then resume same cycle.
    step(1'b1, 1'b0, '0, 1'b0);
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      if (IREQ === 1'b1) nreq++;
    end
    check("stall requests", 64'(nreq), 64'(DEPTH));
    check("stall count", 64'(COUNT), 64'(DEPTH));
    check("stall ireq", 64'(IREQ), 64'(0));
    step(1'b0, 1'b0, '0, 1'b1);
    check("resume ireq", 64'(IREQ), 64'(1));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Redirect with three queued entries and one request in flight.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 30'h100, 1'b1);
    check("redir count before", 64'(COUNT), 64'(3));
    step(1'b0, 1'b0, '0, 1'b1);
    check("redir count after", 64'(COUNT), 64'(0));
    check("redir out_valid", 64'(OUT_VALID), 64'(0));
    check("redir iaddr", 64'(IADDR), 64'(30'h100));
    check("redir ireq", 64'(IREQ), 64'(1));
    wait_valid("redir first", 30'h100);

    // Back-to-back redirects: the second target wins.
    step(1'b0, 1'b1, 30'h40, 1'b1);
    step(1'b0, 1'b1, 30'h80, 1'b1);
    wait_valid("double redir", 30'h80);

    // Mid-operation reset with two queued entries.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("rst count before", 64'(COUNT), 64'(2));
    step(1'b0, 1'b0, '0, 1'b1);
    check("rst count after", 64'(COUNT), 64'(0));
    check("rst out_valid", 64'(OUT_VALID), 64'(0));
    check("rst ireq", 64'(IREQ), 64'(1));
    check("rst iaddr", 64'(IADDR), 64'(RST_A));
    wait_valid("rst first", RST_A);

    // PC wrap on the wide instance (scoreboard follows addresses through 0).
    step(1'b0, 1'b1, 30'h3FFF_FFFE, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Narrow instance free-running from its reset address.
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);
    check("small entries", 64'(s_log.size() >= 4), 64'(1));
    for (int i = 0; i < 4 && i < s_log.size(); i++)
      check($sformatf("small addr %0d", i), 64'(s_log[i]), 64'(exp42[i]));

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      logic          r_rst, r_redir, r_rdy;
      logic [AW-1:0] r_addr;
      r_rst   = ($urandom_range(0, 99) < 2);
      r_redir = ($urandom_range(0, 99) < 5);
      r_rdy   = ($urandom_range(0, 99) < 70);
      r_addr  = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFC : AW'($urandom);
      step(r_rst, r_redir, r_addr, r_rdy);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
